// File: rtl/exu_div_pkg.sv
// Shared types for the execute-stage divider.
// Issue bundle layout, FSM states and operand helpers.
package exu_div_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;
    localparam int TAG_W     = 6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    typedef struct packed {
        logic             div;
        logic             rem;
        logic             unsign;
        logic             legal;
        logic             nop;
        logic             rd;
        logic [4:0]       rd_addr;
        logic [TAG_W-1:0] instr_tag;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
    } idu1_out_t;

    function automatic logic [XLEN-1:0] twos_neg(
        input logic [XLEN-1:0] x
    );
        return ~x + 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] x,
        input logic            sgn
    );
        return (sgn & x[XLEN-1]) ? twos_neg(x) : x;
    endfunction

endpackage

// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// 32 CALC cycles, one-cycle DONE writeback, one-cycle special cases.
module exu_div
    import exu_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  idu1_out_t        idu1_out,
    input  logic             pipe_flush,
    output logic             div_busy,
    output logic             div_wb_valid,
    output logic [XLEN-1:0]  div_wb_data,
    output logic [4:0]       div_wb_rd_addr,
    output logic [TAG_W-1:0] div_wb_instr_tag
);

    div_state_t       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             wr_q, wr_d;
    logic [4:0]       rda_q, rda_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             wbv_q, wbv_d;
    logic [XLEN-1:0]  wbd_q, wbd_d;
    logic [4:0]       wbr_q, wbr_d;
    logic [TAG_W-1:0] wbt_q, wbt_d;

    logic            start, sgn, dz, ovf, wr_in, qbit;
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

    // One restoring step plus the sign fix-up of its result.
    always_comb begin
        sh     = {rem_q, quo_q[XLEN-1]};
        qbit   = sh >= {1'b0, dvs_q};
        rem_nx = qbit ? XLEN'(sh - {1'b0, dvs_q}) : sh[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], qbit};
        q_fix  = q_neg_q ? twos_neg(quo_nx) : quo_nx;
        r_fix  = r_neg_q ? twos_neg(rem_nx) : rem_nx;
    end

    // Next-state, operand latch and writeback register update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        wr_d     = wr_q;
        rda_d    = rda_q;
        tag_d    = tag_q;
        wbv_d    = 1'b0;
        wbd_d    = wbd_q;
        wbr_d    = wbr_q;
        wbt_d    = wbt_q;

        start = idu1_out.div & idu1_out.legal & ~idu1_out.nop
              & ~pipe_flush & (state_q != CALC);
        sgn   = ~idu1_out.unsign;
        dz    = idu1_out.rs2_data == '0;
        ovf   = sgn & (idu1_out.rs1_data == 32'h8000_0000)
              & (idu1_out.rs2_data == '1);
        wr_in = idu1_out.rd & (idu1_out.rd_addr != 5'd0);

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    is_rem_d = idu1_out.rem;
                    q_neg_d  = sgn & (idu1_out.rs1_data[XLEN-1]
                             ^ idu1_out.rs2_data[XLEN-1]);
                    r_neg_d  = sgn & idu1_out.rs1_data[XLEN-1];
                    wr_d     = wr_in;
                    rda_d    = idu1_out.rd_addr;
                    tag_d    = idu1_out.instr_tag;
                    rem_d    = '0;
                    quo_d    = mag(idu1_out.rs1_data, sgn);
                    dvs_d    = mag(idu1_out.rs2_data, sgn);
                    if (dz | ovf) begin
                        state_d = DONE;
                        wbv_d   = wr_in;
                        wbr_d   = idu1_out.rd_addr;
                        wbt_d   = idu1_out.instr_tag;
                        if (idu1_out.rem)
                            wbd_d = dz ? idu1_out.rs1_data : '0;
                        else
                            wbd_d = dz ? '1 : 32'h8000_0000;
                    end else begin
                        state_d = CALC;
                        cnt_d   = 5'(DIV_ITERS - 1);
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = DONE;
                    wbv_d   = wr_q;
                    wbd_d   = is_rem_q ? r_fix : q_fix;
                    wbr_d   = rda_q;
                    wbt_d   = tag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            wr_q     <= 1'b0;
            rda_q    <= '0;
            tag_q    <= '0;
            wbv_q    <= 1'b0;
            wbd_q    <= '0;
            wbr_q    <= '0;
            wbt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            wr_q     <= wr_d;
            rda_q    <= rda_d;
            tag_q    <= tag_d;
            wbv_q    <= wbv_d;
            wbd_q    <= wbd_d;
            wbr_q    <= wbr_d;
            wbt_q    <= wbt_d;
        end
    end

    assign div_busy         = state_q == CALC;
    assign div_wb_valid     = wbv_q;
    assign div_wb_data      = wbd_q;
    assign div_wb_rd_addr   = wbr_q;
    assign div_wb_instr_tag = wbt_q;

endmodule

// File: tb/tb_exu_div.sv
// Directed bench for exu_div.
// Hand-computed quotients, remainders and latencies.
module tb_exu_div;
    import exu_div_pkg::*;

    logic             clk;
    logic             rst_n;
    idu1_out_t        din;
    logic             pipe_flush;
    logic             div_busy;
    logic             div_wb_valid;
    logic [XLEN-1:0]  div_wb_data;
    logic [4:0]       div_wb_rd_addr;
    logic [TAG_W-1:0] div_wb_instr_tag;

    int checks = 0;
    int errors = 0;

    exu_div u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .idu1_out         (din),
        .pipe_flush       (pipe_flush),
        .div_busy         (div_busy),
        .div_wb_valid     (div_wb_valid),
        .div_wb_data      (div_wb_data),
        .div_wb_rd_addr   (div_wb_rd_addr),
        .div_wb_instr_tag (div_wb_instr_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic rm,
                         input logic un, input logic rd,
                         input logic [4:0] rda,
                         input logic [TAG_W-1:0] tg,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic fl);
        din           = '0;
        din.div       = dv;
        din.rem       = rm;
        din.unsign    = un;
        din.legal     = 1'b1;
        din.rd        = rd;
        din.rd_addr   = rda;
        din.instr_tag = tg;
        din.rs1_data  = a;
        din.rs2_data  = b;
        pipe_flush    = fl;
    endtask

    task automatic idle_in();
        din        = '0;
        pipe_flush = 1'b0;
    endtask

    // Issue one op on the next edge, then watch 40 cycles.
    task automatic run_op(input string tag,
                          input logic rm, input logic un,
                          input logic rd, input logic [4:0] rda,
                          input logic [TAG_W-1:0] tg,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic fl,
                          input logic [31:0] exp_d,
                          input int exp_lat,
                          input int exp_busy);
        int lat = 0, nbusy = 0, nvld = 0;
        logic [31:0] d = '0;
        logic [4:0] r = '0;
        logic [TAG_W-1:0] t = '0;
        drive(1'b1, rm, un, rd, rda, tg, a, b, fl);
        @(posedge clk);
        #1 idle_in();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (div_busy) nbusy++;
            if (div_wb_valid) begin
                nvld++;
                lat = n;
                d = div_wb_data;
                r = div_wb_rd_addr;
                t = div_wb_instr_tag;
            end
        end
        chk({tag, "_busy"}, nbusy, exp_busy);
        chk({tag, "_nvld"}, nvld, (exp_lat != 0) ? 1 : 0);
        chk({tag, "_lat"}, lat, exp_lat);
        if (exp_lat != 0) begin
            chk({tag, "_data"}, d, exp_d);
            chk({tag, "_rd"}, {27'd0, r}, {27'd0, rda});
            chk({tag, "_tag"}, {26'd0, t}, {26'd0, tg});
        end
    endtask

    initial begin
        int n;
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, div_busy}, 0);
        chk("rst_vld", {31'd0, div_wb_valid}, 0);
        chk("rst_data", div_wb_data, 0);
        chk("rst_rd", {27'd0, div_wb_rd_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu", 0, 1, 1, 5, 1, 20, 3, 0, 6, 33, 32);
        run_op("remu", 1, 1, 1, 5, 2, 20, 3, 0, 2, 33, 32);
        run_op("div_n7_2", 0, 0, 1, 6, 3, -7, 2, 0,
               32'hFFFF_FFFD, 33, 32);
        run_op("rem_n7_2", 1, 0, 1, 7, 4, -7, 2, 0,
               32'hFFFF_FFFF, 33, 32);
        run_op("rem_7_n2", 1, 0, 1, 8, 5, 7, -2, 0, 1, 33, 32);
        run_op("div_7_n2", 0, 0, 1, 8, 6, 7, -2, 0,
               32'hFFFF_FFFD, 33, 32);
        run_op("divu_big", 0, 1, 1, 9, 7, 32'hFFFF_FFFF, 2, 0,
               32'h7FFF_FFFF, 33, 32);
        run_op("div_100_7", 0, 0, 1, 31, 63, 100, 7, 0, 14, 33, 32);
        run_op("div_z", 0, 0, 1, 10, 8, 5, 0, 0,
               32'hFFFF_FFFF, 1, 0);
        run_op("remu_z", 1, 1, 1, 11, 9, 5, 0, 0, 5, 1, 0);
        run_op("div_ovf", 0, 0, 1, 12, 10, 32'h8000_0000,
               32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", 1, 0, 1, 13, 11, 32'h8000_0000,
               32'hFFFF_FFFF, 0, 0, 1, 0);
        run_op("flush", 0, 1, 1, 14, 12, 20, 3, 1, 0, 0, 0);
        run_op("rd_x0", 0, 1, 1, 0, 13, 20, 3, 0, 0, 0, 32);
        run_op("rd_off", 0, 1, 0, 15, 14, 20, 3, 0, 0, 0, 32);

        // Back-to-back: second start in the first's DONE cycle.
        drive(1'b1, 0, 1, 1, 3, 21, 100, 7, 0);
        @(posedge clk);
        #1 idle_in();
        n = 0;
        for (int i = 1; i <= 40 && !div_wb_valid; i++) begin
            @(negedge clk);
            n = i;
        end
        chk("b2b_lat1", n, 33);
        chk("b2b_data1", div_wb_data, 14);
        drive(1'b1, 1, 1, 1, 4, 22, 100, 7, 0);
        @(posedge clk);
        #1 idle_in();
        @(negedge clk);
        chk("b2b_busy", {31'd0, div_busy}, 1);
        chk("b2b_vld_off", {31'd0, div_wb_valid}, 0);
        n = 1;
        for (int i = 2; i <= 40 && !div_wb_valid; i++) begin
            @(negedge clk);
            n = i;
        end
        chk("b2b_lat2", n, 33);
        chk("b2b_data2", div_wb_data, 2);
        chk("b2b_tag2", {26'd0, div_wb_instr_tag}, 22);
        repeat (3) @(negedge clk);

        // Reset in the middle of iterating.
        drive(1'b1, 0, 1, 1, 17, 30, 20, 3, 0);
        @(posedge clk);
        #1 idle_in();
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", {31'd0, div_busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, div_busy}, 0);
        chk("mid_vld", {31'd0, div_wb_valid}, 0);
        chk("mid_data", div_wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_wb_valid || div_busy) n++;
        end
        chk("mid_quiet", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
